// File: rtl/ifetch_buffer.sv
// Instruction prefetcher: walks fetch_pc through a combinational-read instruction
// memory and queues {pc, instr, fault} entries in a small FIFO for the decoder.
module ifetch_buffer #(
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int          IDX_W     = 11,
  parameter int          DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [IDX_W-1:0]           imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic                       out_fault,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {FETCH, HALT} state_t;

  state_t         state, stateNext;
  logic [31:0]    fetchPc;
  logic [31:0]    offset;
  logic           fetchFault;
  logic           full;
  logic           push;
  logic           advance;
  logic           pop;
  logic [PW-1:0]  head, tail;
  logic [LW-1:0]  count;

  logic [31:0]      pcMem    [DEPTH];
  logic [31:0]      instrMem [DEPTH];
  logic [DEPTH-1:0] faultMem;

  // Offsets below BASE_ADDR wrap to huge values and so land in the range fault.
  assign offset     = fetchPc - BASE_ADDR;
  assign imem_addr  = offset[IDX_W+1:2];
  assign fetchFault = (offset[1:0] != 2'b00) || ({1'b0, offset} >= (33'd4 << IDX_W));

  assign full      = (count == LW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign level     = count;

  assign out_pc    = pcMem[head];
  assign out_instr = instrMem[head];
  assign out_fault = faultMem[head];

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (redirect_valid)
      stateNext = FETCH;
    else if (state == FETCH && !full && fetchFault)
      stateNext = HALT;
  end

  always_comb begin
    push    = (state == FETCH) && !full;
    advance = push && !fetchFault;
  end

  always_ff @(posedge clk) begin
    if (rst)                 fetchPc <= BASE_ADDR;
    else if (redirect_valid) fetchPc <= redirect_pc;
    else if (advance)        fetchPc <= fetchPc + 32'd4;
  end

  // Storage is cleared on reset so the head outputs read zero rather than X.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      faultMem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcMem[i]    <= '0;
        instrMem[i] <= '0;
      end
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pcMem[tail]    <= fetchPc;
        instrMem[tail] <= fetchFault ? 32'h0 : imem_rdata;
        faultMem[tail] <= fetchFault;
        tail           <= tail + PW'(1);
      end
      if (pop)
        head <= head + PW'(1);
      count <= count + LW'(push) - LW'(pop);
    end
  end

endmodule
